cordic_result_collector: RTL and testbench

Capture end of the CORDIC datapath. Takes the `res1`/`res2` result pairs coming out of `cordic`, throws away the first `SKIP` samples of a run while the pipeline fills, and buffers the remaining samples of a `TOTAL`-sample run in a first-word-fall-through FIFO. The buffered pairs leave through a valid/ready stream for downstream logging or checking. Run bookkeeping (busy, done, overflow, capture count) is exposed as status outputs.

---
 rtl/cordic_result_collector.sv | 115 +++++++++++
 tb/tb_cordic_result_collector.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cordic_result_collector.sv
// cordic_result_collector: skips warm-up samples, buffers a CORDIC run in a FWFT FIFO; checksum under CORDIC_COLLECT_CHECKSUM_EN
module cordic_result_collector #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int SKIP  = 11,
  parameter int TOTAL = 300
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] res1,
  input  logic [WIDTH-1:0] res2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res1,
  output logic [WIDTH-1:0] out_res2,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [15:0]      captured_count,
  output logic [WIDTH-1:0] checksum
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, WARMUP, CAPTURE, DRAIN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_mem1 [DEPTH];
  logic [WIDTH-1:0] r_mem2 [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic [15:0]      r_sample_cnt, r_captured;
  logic             r_busy, r_done, r_ovf;
  logic             w_empty, w_full, w_pop, w_take, w_push, w_drop, w_idle_start;
  logic [AW:0]      w_cnt_nxt;
  assign w_empty      = r_cnt == '0;
  assign w_full       = r_cnt == (AW+1)'(DEPTH);
  assign w_pop        = !w_empty && out_ready;
  assign w_take       = r_state == CAPTURE && in_valid;
  assign w_push       = w_take && (!w_full || w_pop);
  assign w_drop       = w_take && w_full && !w_pop;
  assign w_cnt_nxt    = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_idle_start = (r_state == IDLE || r_state == DONE) && start;
  assign out_valid      = !w_empty;
  assign out_res1       = w_empty ? '0 : r_mem1[r_rd];
  assign out_res2       = w_empty ? '0 : r_mem2[r_rd];
  assign busy           = r_busy;
  assign done           = r_done;
  assign overflow       = r_ovf;
  assign captured_count = r_captured;
  // run control, FIFO pointers/occupancy and registered status
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wr         <= '0;
      r_rd         <= '0;
      r_cnt        <= '0;
      r_sample_cnt <= '0;
      r_captured   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state      <= SKIP == 0 ? CAPTURE : WARMUP;
          r_sample_cnt <= '0;
          r_captured   <= '0;
          r_ovf        <= 1'b0;
          r_wr         <= '0;
          r_rd         <= '0;
          r_cnt        <= '0;
          r_busy       <= 1'b1;
          r_done       <= 1'b0;
        end
        WARMUP: if (in_valid) begin
          r_sample_cnt <= r_sample_cnt + 16'd1;
          if (r_sample_cnt == 16'(SKIP - 1)) r_state <= CAPTURE;
        end
        CAPTURE: if (in_valid) begin
          r_sample_cnt <= r_sample_cnt + 16'd1;
          if (w_push && r_captured != 16'hFFFF) r_captured <= r_captured + 16'd1;
          if (w_drop) r_ovf <= 1'b1;
          if (r_sample_cnt == 16'(TOTAL - 1)) r_state <= DRAIN;
        end
        DRAIN: if (w_cnt_nxt == '0) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // FIFO storage; contents need no reset since occupancy gates the head
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem1[r_wr] <= res1;
      r_mem2[r_wr] <= res2;
    end
  end
`ifdef CORDIC_COLLECT_CHECKSUM_EN
  logic [WIDTH-1:0] r_checksum;
  assign checksum = r_checksum;
  // sum of every capture-window sample, dropped ones included
  always_ff @(posedge clk) begin
    if (reset || w_idle_start) r_checksum <= '0;
    else if (w_take) r_checksum <= r_checksum + res1 + res2;
  end
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_cordic_result_collector.sv
// tb_cordic_result_collector: randomized and directed runs against a queue-based reference model
module tb_cordic_result_collector;
  localparam int D  = 16;
  localparam int SK = 11;
  localparam int TT = 300;
  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [15:0] res1, res2, out_res1, out_res2, checksum, captured_count;
  logic        out_valid, busy, done, overflow;
  cordic_result_collector dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .res1(res1), .res2(res2), .out_valid(out_valid), .out_ready(out_ready),
    .out_res1(out_res1), .out_res2(out_res2), .busy(busy), .done(done),
    .overflow(overflow), .captured_count(captured_count), .checksum(checksum)
  );
  always #5 clk = ~clk;
  logic [31:0] mq[$];
  int          log_q[$];
  int          m_idx, sidx, dmode, n_chk, n_bad;
  logic        m_busy, m_done, m_ovf;
  logic [15:0] m_cap, m_sum;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic rdy(int m);
    return m == 2 ? 1'($urandom % 2) : 1'(m);
  endfunction
  function automatic logic [15:0] da();
    return dmode == 0 ? 16'(sidx) : dmode == 1 ? 16'd1 : 16'($urandom);
  endfunction
  function automatic logic [15:0] db();
    return dmode == 0 ? ~16'(sidx) : dmode == 1 ? 16'd2 : 16'($urandom);
  endfunction
  task automatic cyc(logic st, logic v, logic [15:0] a, logic [15:0] b, logic rd, logic rs);
    logic pop, room;
    start = st; in_valid = v; res1 = a; res2 = b; out_ready = rd; reset = rs;
    if (out_valid && rd && !rs) log_q.push_back(int'(out_res1));
    pop  = mq.size() > 0 && rd;
    room = mq.size() < D || pop;
    @(posedge clk);
    #1;
    if (rs) begin
      mq.delete(); m_idx = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_cap = 0; m_sum = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (!m_busy && st) begin
        mq.delete(); m_idx = 0; m_cap = 0; m_ovf = 0; m_sum = 0; m_busy = 1; m_done = 0;
      end else if (m_busy && m_idx < TT && v) begin
        if (m_idx >= SK) begin
          m_sum += a + b;
          if (room) begin
            mq.push_back({a, b});
            if (m_cap != 16'hFFFF) m_cap++;
          end else m_ovf = 1;
        end
        m_idx++;
      end
      if (m_busy && m_idx == TT && mq.size() == 0) begin
        m_busy = 0; m_done = 1;
      end
    end
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_res1", out_res1, mq[0][31:16]);
      chk("out_res2", out_res2, mq[0][15:0]);
    end
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
    chk("captured", captured_count, m_cap);
`ifdef CORDIC_COLLECT_CHECKSUM_EN
    chk("checksum", checksum, m_sum);
`else
    chk("checksum", checksum, 16'h0);
`endif
  endtask
  task automatic idle(logic rd);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, rd, 1'b0);
  endtask
  task automatic send(int n, int gap, int rmode);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) idle(rdy(rmode));
      cyc(1'b0, 1'b1, da(), db(), rdy(rmode), 1'b0);
      sidx++;
    end
  endtask
  task automatic begin_run();
    log_q.delete();
    sidx = 0;
    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask
  task automatic finish_run();
    for (int i = 0; i < 2000 && !done; i++) idle(1'b1);
    chk("run_done", done, 1'b1);
  endtask
  int gaps;
  initial begin
    start = 0; in_valid = 0; out_ready = 0; res1 = 0; res2 = 0; reset = 1;
    dmode = 0; n_chk = 0; n_bad = 0;
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("rst_res1", out_res1, 16'h0);
    chk("rst_res2", out_res2, 16'h0);
    idle(1'b0);
    begin_run();
    send(TT, 0, 1);
    finish_run();
    chk("s1_n", log_q.size(), 289);
    chk("s1_first", log_q[0], 11);
    chk("s1_last", log_q[$], 299);
    chk("s1_cap", captured_count, 16'd289);
    chk("s1_ovf", overflow, 1'b0);
    begin_run();
    send(31, 0, 0);
    chk("s2_ovf", overflow, 1'b1);
    chk("s2_cap", captured_count, 16'd16);
    log_q.delete();
    for (int i = 0; i < 16; i++) idle(1'b1);
    chk("s2_n", log_q.size(), 16);
    gaps = 0;
    for (int i = 0; i < log_q.size(); i++) if (log_q[i] != 11 + i) gaps++;
    chk("s2_order", gaps, 0);
    send(TT - 31, 0, 2);
    finish_run();
    begin_run();
    send(TT, 2, 1);
    finish_run();
    chk("s3_n", log_q.size(), 289);
    gaps = 0;
    for (int i = 0; i < log_q.size(); i++) if (log_q[i] != 11 + i) gaps++;
    chk("s3_seq", gaps, 0);
    begin_run();
    send(27, 0, 0);
    chk("s4_cap16", captured_count, 16'd16);
    send(1, 0, 1);
    chk("s4_ovf", overflow, 1'b0);
    chk("s4_cap17", captured_count, 16'd17);
    send(TT - 28, 0, 1);
    finish_run();
    begin_run();
    send(50, 0, 2);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("s5_valid", out_valid, 1'b0);
    chk("s5_busy", busy, 1'b0);
    idle(1'b0);
    begin_run();
    send(TT, 0, 1);
    finish_run();
    chk("s5_first", log_q[0], 11);
    chk("s5_n", log_q.size(), 289);
    dmode = 2;
    repeat (3) begin
      begin_run();
      for (int i = 0; i < 4000 && !done; i++) begin
        logic v;
        v = 1'($urandom % 2);
        cyc(1'($urandom % 16 == 0), v, da(), db(), rdy(2), 1'b0);
      end
      chk("rnd_done", done, 1'b1);
    end
    dmode = 1;
    begin_run();
    send(TT, 0, 1);
    finish_run();
`ifdef CORDIC_COLLECT_CHECKSUM_EN
    chk("s6_csum", checksum, 16'd867);
`else
    chk("s6_csum", checksum, 16'd0);
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
